// File: rtl/settings_readback_handler.sv
// settings_readback_handler: snapshots the live settings and serialises them into a byte
// buffer RAM as id + 32-bit little-endian records. Define SETTINGS_READBACK_CHECKSUM_EN to append an XOR byte.
module settings_readback_handler #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        req_id,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        tx_len,
    input  logic [31:0]       settings_max_row,
    input  logic [31:0]       settings_max_col,
    input  logic [31:0]       settings_data_min,
    input  logic [31:0]       settings_data_max,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [7:0]        ram_wr_data
);

`ifdef SETTINGS_READBACK_CHECKSUM_EN
    localparam logic [7:0] RECORD_LEN = 8'd6;
`else
    localparam logic [7:0] RECORD_LEN = 8'd5;
`endif
    localparam logic [2:0] LAST_BYTE = 3'(RECORD_LEN - 8'd1);

    typedef enum logic [1:0] {IDLE, EMIT, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [2:0]        byte_q, byte_d;
    logic [1:0]        rec_q, rec_d;
    logic [1:0]        rec_last_q, rec_last_d;
    logic [7:0]        id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flushed_q, flushed_d;
    logic              snap_en;
    logic [3:0][31:0]  snap_q;

    logic              busy_d, done_d, error_d, wr_en_d;
    logic [7:0]        tx_len_d, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_d;

    logic [1:0]        sel;
    logic [31:0]       cur_val;
    logic [7:0]        byte_data;
`ifdef SETTINGS_READBACK_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign sel     = 2'(id_q - 8'd1);
    assign cur_val = snap_q[sel];

    always_comb begin
        case (byte_q)
            3'd0:    byte_data = id_q;
            3'd1:    byte_data = cur_val[7:0];
            3'd2:    byte_data = cur_val[15:8];
            3'd3:    byte_data = cur_val[23:16];
            3'd4:    byte_data = cur_val[31:24];
`ifdef SETTINGS_READBACK_CHECKSUM_EN
            default: byte_data = csum_q;
`else
            default: byte_data = 8'h00;
`endif
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        byte_d     = byte_q;
        rec_d      = rec_q;
        rec_last_d = rec_last_q;
        id_d       = id_q;
        addr_d     = addr_q;
        flushed_d  = flushed_q;
        snap_en    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        wr_en_d    = 1'b0;
        tx_len_d   = tx_len;
        wr_addr_d  = ram_wr_addr;
        wr_data_d  = ram_wr_data;
`ifdef SETTINGS_READBACK_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_id <= 8'd4) begin
                        state_d   = EMIT;
                        snap_en   = 1'b1;
                        byte_d    = 3'd0;
                        rec_d     = 2'd0;
                        addr_d    = '0;
                        flushed_d = 1'b0;
                        if (req_id == 8'd0) begin
                            id_d       = 8'd1;
                            rec_last_d = 2'd3;
                        end else begin
                            id_d       = req_id;
                            rec_last_d = 2'd0;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            EMIT: begin
                if (flushed_q) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    tx_len_d = (rec_last_q == 2'd3) ? RECORD_LEN * 8'd4 : RECORD_LEN;
                end else begin
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = byte_data;
                    addr_d    = addr_q + 1'b1;
`ifdef SETTINGS_READBACK_CHECKSUM_EN
                    csum_d    = (byte_q == 3'd0) ? byte_data : (csum_q ^ byte_data);
`endif
                    if (byte_q == LAST_BYTE) begin
                        byte_d = 3'd0;
                        id_d   = id_q + 8'd1;
                        if (rec_q == rec_last_q) flushed_d = 1'b1;
                        else                     rec_d     = rec_q + 2'd1;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     error_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_q      <= 3'd0;
            rec_q       <= 2'd0;
            rec_last_q  <= 2'd0;
            id_q        <= 8'd0;
            addr_q      <= '0;
            flushed_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            tx_len      <= 8'd0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= 8'd0;
`ifdef SETTINGS_READBACK_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            rec_q       <= rec_d;
            rec_last_q  <= rec_last_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            flushed_q   <= flushed_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            tx_len      <= tx_len_d;
            ram_wr_en   <= wr_en_d;
            ram_wr_addr <= wr_addr_d;
            ram_wr_data <= wr_data_d;
`ifdef SETTINGS_READBACK_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // NOTE: the snapshot is deliberately not reset; it is only read after being loaded on acceptance.
    always_ff @(posedge clk) begin
        if (snap_en)
            snap_q <= {settings_data_max, settings_data_min, settings_max_col, settings_max_row};
    end

endmodule
